// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-port, byte-addressed memory between the MIPS
//   instruction-fetch path and the load/store data path. One transaction is
//   in flight at a time, and each transaction walks IDLE -> ACCESS -> DONE.
//   Each requester gets back a registered read word and a one-cycle
//   completion pulse. A misaligned request never writes memory, returns 0,
//   and completes with err set.
//
// Configuration:
//   MEM_ARB_RR_EN  defined   : round-robin on simultaneous requests. The
//                              requester that did not own the previous
//                              transaction wins.
//                  undefined : fixed priority. Data always beats fetch.
//
// Ports:
//   clk, rst_n           single clock, asynchronous active-low reset
//   i_req, i_addr        fetch request and byte address
//   i_rdata, i_valid     fetched word (registered), completion pulse
//   d_req, d_we          data request, 1 = store / 0 = load
//   d_addr, d_wdata      data byte address and store data
//   d_rdata, d_valid     loaded word (registered), completion pulse
//   err                  pulses with *_valid for a misaligned request
//   busy                 high whenever the FSM is not IDLE
//   m_we, m_addr, m_wd   drive the memory's we/addr/wd
//   m_rd                 the memory's read data
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          err,
    output logic          busy,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wd,
    input  logic [DW-1:0] m_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state;
    logic          owner_d;     // 1 = data path owns the current transaction
    logic          grant_d;
    logic [AW-1:0] sel_addr;
    logic          sel_aligned;
    logic [DW-1:0] capture;

`ifdef MEM_ARB_RR_EN
    logic          last_d;      // owner of the previous transaction, 0 = fetch
`endif

    // Winner for this IDLE sample. A lone requester always wins. Only a tie
    // depends on the build option.
    always_comb begin
        grant_d = d_req;
        if (d_req && i_req) begin
`ifdef MEM_ARB_RR_EN
            grant_d = ~last_d;
`else
            grant_d = 1'b1;
`endif
        end
    end

    assign sel_addr    = grant_d ? d_addr : i_addr;
    assign sel_aligned = (sel_addr[1:0] == 2'b00);

    // m_addr holds the latched address during ACCESS. A misaligned access
    // returns 0 instead of whatever the memory presents.
    assign capture = (m_addr[1:0] == 2'b00) ? m_rd : '0;

    // Single FSM with registered outputs. m_addr/m_wd double as the latched
    // request registers, so they naturally hold their value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wd    <= '0;
`ifdef MEM_ARB_RR_EN
            last_d  <= 1'b0;
`endif
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state   <= ACCESS;
                        busy    <= 1'b1;
                        owner_d <= grant_d;
                        m_addr  <= sel_addr;
                        if (grant_d) begin
                            m_wd <= d_wdata;
                        end
                        // The write strobe is already qualified, so a
                        // misaligned store never reaches the memory.
                        m_we    <= grant_d & d_we & sel_aligned;
`ifdef MEM_ARB_RR_EN
                        last_d  <= grant_d;
`endif
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    m_we  <= 1'b0;
                    if (owner_d) begin
                        d_rdata <= capture;
                    end else begin
                        i_rdata <= capture;
                    end
                    d_valid <= owner_d;
                    i_valid <= ~owner_d;
                    err     <= (m_addr[1:0] != 2'b00);
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    m_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
